fft_frame_collector: RTL and testbench
======================================

// Module: fft_frame_collector
// PURPOSE
//  Serial-to-parallel input stage feeding full_parallel_fft. Accepts one complex sample per cycle.
//  Assembles frames of 2**NPOINT samples in a ping-pong (two-bank) buffer.
//  Presents each complete frame as packed din_real/din_imag words, matching the FFT's valid/busy input.
// PARAMETERS
//  NPOINT  3   log2 of frame length; N = 2**NPOINT samples per frame
//  WIDTH   16  bits per real/imag component, two's complement
// PORTS
//  clk         in   1          clock, all state on rising edge
//  rst_n       in   1          asynchronous reset, active low
//  din_valid   in   1          input sample valid
//  din_busy    out  1          collector cannot accept; sample accepted iff din_valid && !din_busy
//  din_sof     in   1          start of frame, qualified by acceptance
//  din_real    in   WIDTH      sample real part
//  din_imag    in   WIDTH      sample imag part
//  dout_valid  out  1          complete frame presented
//  dout_busy   in   1          FFT busy; frame transferred iff dout_valid && !dout_busy
//  dout_real   out  WIDTH*N    slot i at [i*WIDTH +: WIDTH]
//  dout_imag   out  WIDTH*N    slot i at [i*WIDTH +: WIDTH]
//  frame_drop  out  1          one-cycle pulse: partial frame discarded by din_sof
// BEHAVIOUR
//  Reset values
//   - din_busy=0, dout_valid=0, frame_drop=0, dout_real/imag=0.
//   - Pointers wbank=0, rbank=0; both banks marked empty; idx=0.
//  Bank state: full[b] flag per bank; write bank wbank, read bank rbank, sample index idx (NPOINT bits).
//  Input acceptance (din_valid && !din_busy):
//   - Write sample into bank[wbank] at slot idx; idx increments.
//   - When idx==N-1: set full[wbank], toggle wbank, wrap idx to 0.
//  din_sof
//   - If din_sof is accepted with idx!=0: abandon the partial frame, write the sample at slot 0, set idx=1, pulse frame_drop.
//   - din_sof with idx==0 is normal. N==1 is not supported (NPOINT>=1).
//  din_busy = full[wbank], registered from state.
//   - No combinational path from dout_busy to din_busy.
//   - The last sample of a frame is accepted even if the other bank is full; busy rises the next cycle.
//  dout_valid = full[rbank]; dout_real/imag = bank[rbank] contents, stable while dout_valid && dout_busy.
//  Output transfer (dout_valid && !dout_busy): clear full[rbank], toggle rbank.
//  Latency: last sample accepted at edge t -> dout_valid high after edge t (visible cycle t+1) when rbank was empty.
//  Throughput: sustained 1 sample/cycle when the FFT takes each frame within N cycles.
//  Simultaneous completion and transfer of different banks in one cycle: both take effect. Nothing is lost or duplicated.
//  Reset mid-frame or mid-transfer: all frames discarded, return to reset state immediately (asynchronous).
//  Data is stored unmodified; no arithmetic, no saturation.
// CONFIGURATION
//  FFT_BITREV_EN defined:
//   - Sample with in-frame index k is stored at slot bitrev_NPOINT(k).
//   - The output is in bit-reversed order, for a decimation-in-time FFT.
//  Undefined: sample k stored at slot k (natural order). Handshake and timing are identical either way.
// STRUCTURE
//  Package fft_pkg:
//   - function bitrev(idx, NPOINT).
//   - typedef of a complex sample {real, imag} of WIDTH bits.
//   - localparam helpers N=2**NPOINT.
//  Sub-module fft_frame_bank: one N x 2*WIDTH register bank with write enable and slot address, plus a packed read-out.
//   - Instantiated twice.
//  Top module holds pointers, idx, the full flags and the output mux.
// TESTING
//  1. Reset, then feed 8 samples real=0..7, imag=0, sof on first, dout_busy=0.
//     -> dout_valid one cycle after the 8th; slot i real=i (with FFT_BITREV_EN: slot i real=bitrev3(i)).
//  2. Hold dout_busy=1, stream 24 samples.
//     -> frames 1 and 2 buffered; din_busy rises after the 16th accept.
//     -> release busy: frames pop in order, then frame 3 completes; no sample lost.
//  3. Continuous stream, dout_busy=0 always, 5 frames.
//     -> din_busy never asserts; 5 dout_valid transfers, 8 cycles apart.
//  4. Send 3 samples, then sof with real=100.
//     -> frame_drop pulses once; the next frame's slot 0 real=100.
//  5. Assert rst_n=0 after 5 samples of a frame with the other bank full.
//     -> all outputs at reset values; the next 8 samples form a clean frame.
//  6. Full-scale values 0x7FFF/0x8000 in real and imag.
//     -> output bit-exact, no sign corruption.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame collector: frame length, bit reversal and a complex sample type.
package fft_pkg;

  localparam int DEF_NPOINT = 3;
  localparam int DEF_WIDTH  = 16;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] re;
    logic [DEF_WIDTH-1:0] im;
  } cplx_t;

  function automatic int npoints(input int np);
    return 1 << np;
  endfunction

  // Reverses the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < nbits) r = {r[30:0], idx[b]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of storage: N complex slots written one at a time, read out as packed real/imag words.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int NPOINT = DEF_NPOINT,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_we,
  input  logic [NPOINT-1:0]                   i_addr,
  input  logic [WIDTH-1:0]                    i_real,
  input  logic [WIDTH-1:0]                    i_imag,
  output logic [WIDTH*(2**NPOINT)-1:0]        o_real,
  output logic [WIDTH*(2**NPOINT)-1:0]        o_imag
);

  localparam int N = npoints(NPOINT);

  logic [WIDTH-1:0] r_re [N];
  logic [WIDTH-1:0] r_im [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N; s++) begin
        r_re[s] <= '0;
        r_im[s] <= '0;
      end
    end else if (i_we) begin
      r_re[i_addr] <= i_real;
      r_im[i_addr] <= i_imag;
    end
  end

  always_comb begin
    o_real = '0;
    o_imag = '0;
    for (int s = 0; s < N; s++) begin
      o_real[s*WIDTH +: WIDTH] = r_re[s];
      o_imag[s*WIDTH +: WIDTH] = r_im[s];
    end
  end

endmodule

// File: rtl/fft_frame_collector.sv
// Serial-to-parallel ping-pong frame collector in front of the parallel FFT.
// Define FFT_BITREV_EN to store each frame in bit-reversed slot order.
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int NPOINT = DEF_NPOINT,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din_valid,
  output logic                         din_busy,
  input  logic                         din_sof,
  input  logic [WIDTH-1:0]             din_real,
  input  logic [WIDTH-1:0]             din_imag,
  output logic                         dout_valid,
  input  logic                         dout_busy,
  output logic [WIDTH*(2**NPOINT)-1:0] dout_real,
  output logic [WIDTH*(2**NPOINT)-1:0] dout_imag,
  output logic                         frame_drop
);

  localparam int N = npoints(NPOINT);
  localparam logic [NPOINT-1:0] LAST = NPOINT'(N - 1);

  // Handshakes: a sample moves when din_valid && !din_busy; a frame moves when dout_valid && !dout_busy.
  logic [1:0]        r_full;
  logic              r_wbank;
  logic              r_rbank;
  logic [NPOINT-1:0] r_idx;
  logic              r_drop;

  logic              w_accept;
  logic              w_restart;
  logic              w_complete;
  logic              w_transfer;
  logic [NPOINT-1:0] w_k;
  logic [NPOINT-1:0] w_addr;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;
  logic [WIDTH*N-1:0] w_real0, w_imag0, w_real1, w_imag1;

  assign din_busy   = r_full[r_wbank];
  assign dout_valid = r_full[r_rbank];
  assign frame_drop = r_drop;

  assign w_accept   = din_valid & ~din_busy;
  assign w_restart  = w_accept & din_sof & (r_idx != '0);
  assign w_k        = w_restart ? '0 : r_idx;
  assign w_complete = w_accept & ~w_restart & (r_idx == LAST);
  assign w_transfer = dout_valid & ~dout_busy;

`ifdef FFT_BITREV_EN
  assign w_addr = NPOINT'(bitrev(32'(w_k), NPOINT));
`else
  assign w_addr = w_k;
`endif

  // Completion and transfer always target different banks, so both can apply in one cycle.
  assign w_set = w_complete ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_transfer ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 2'b00;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
      r_idx   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;
      r_drop <= w_restart;
      if (w_accept)   r_idx   <= w_restart ? NPOINT'(1) : r_idx + 1'b1;
      if (w_complete) r_wbank <= ~r_wbank;
      if (w_transfer) r_rbank <= ~r_rbank;
    end
  end

  fft_frame_bank #(.NPOINT(NPOINT), .WIDTH(WIDTH)) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_accept & ~r_wbank),
    .i_addr (w_addr),
    .i_real (din_real),
    .i_imag (din_imag),
    .o_real (w_real0),
    .o_imag (w_imag0)
  );

  fft_frame_bank #(.NPOINT(NPOINT), .WIDTH(WIDTH)) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_accept & r_wbank),
    .i_addr (w_addr),
    .i_real (din_real),
    .i_imag (din_imag),
    .o_real (w_real1),
    .o_imag (w_imag1)
  );

  assign dout_real = r_rbank ? w_real1 : w_real0;
  assign dout_imag = r_rbank ? w_imag1 : w_imag0;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Bench for fft_frame_collector (NPOINT=3, WIDTH=16): directed table, corner sequences, random traffic vs a frame-queue model.
module tb_fft_frame_collector;
  import fft_pkg::*;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           din_valid, din_sof, din_busy;
  logic [W-1:0]   din_real, din_imag;
  logic           dout_valid, dout_busy, frame_drop;
  logic [W*N-1:0] dout_real, dout_imag;

  always #5 clk = ~clk;

  fft_frame_collector #(.NPOINT(3), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_busy   (din_busy),
    .din_sof    (din_sof),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .dout_valid (dout_valid),
    .dout_busy  (dout_busy),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .frame_drop (frame_drop)
  );

  // Model: completed frames (natural order, {imag, real}) waiting for the FFT, plus the partial frame.
  logic [2*N*W-1:0] exp_q[$];
  logic [W-1:0]     cur_re[$];
  logic [W-1:0]     cur_im[$];
  logic             exp_drop;
  int               xfer_cyc[$];
  int               n_xfer, obs_drop, cycle;
  int               checks, failures;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int slot_of(input int k);
    int r;
    r = k;
`ifdef FFT_BITREV_EN
    r = 0;
    for (int b = 0; b < 3; b++) r = r * 2 + ((k >> b) & 1);
`endif
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur_re.delete();
    cur_im.delete();
    exp_drop = 1'b0;
  endtask

  task automatic check_outputs();
    logic [127:0]     er, ei;
    logic [2*N*W-1:0] f;
    chk("din_busy", 128'(din_busy), 128'(exp_q.size() == 2));
    chk("dout_valid", 128'(dout_valid), 128'(exp_q.size() > 0));
    chk("frame_drop", 128'(frame_drop), 128'(exp_drop));
    obs_drop += int'(frame_drop);
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      er = '0;
      ei = '0;
      for (int k = 0; k < N; k++) begin
        er[slot_of(k)*W +: W] = f[k*W +: W];
        ei[slot_of(k)*W +: W] = f[N*W + k*W +: W];
      end
      chk("dout_real", dout_real, er);
      chk("dout_imag", dout_imag, ei);
    end
  endtask

  // Called at a falling edge; returns whether the sample was taken at the following rising edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] re, input logic [W-1:0] im,
                      output logic acc);
    logic             xfer;
    logic [2*N*W-1:0] f;
    din_valid = v;
    din_sof   = s;
    din_real  = re;
    din_imag  = im;
    acc  = v && (exp_q.size() != 2);
    xfer = (exp_q.size() > 0) && !dout_busy;
    @(posedge clk);
    exp_drop = acc && s && (cur_re.size() != 0);
    if (xfer) begin
      void'(exp_q.pop_front());
      n_xfer++;
      xfer_cyc.push_back(cycle);
    end
    if (acc) begin
      if (exp_drop) begin
        cur_re.delete();
        cur_im.delete();
      end
      cur_re.push_back(re);
      cur_im.push_back(im);
      if (cur_re.size() == N) begin
        for (int k = 0; k < N; k++) begin
          f[k*W +: W]       = cur_re[k];
          f[N*W + k*W +: W] = cur_im[k];
        end
        exp_q.push_back(f);
        cur_re.delete();
        cur_im.delete();
      end
    end
    @(negedge clk);
    cycle++;
    check_outputs();
  endtask

  typedef struct {
    logic         sof;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         exp_valid;
  } vec_t;

  vec_t tab[16];

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 128'(din_busy), 128'(0));
    chk({tag, "_valid"}, 128'(dout_valid), 128'(0));
    chk({tag, "_drop"}, 128'(frame_drop), 128'(0));
    chk({tag, "_real"}, dout_real, 128'(0));
    chk({tag, "_imag"}, dout_imag, 128'(0));
  endtask

  initial begin
    logic  acc;
    int    sent, base_x, base_d;
    logic  busy_seen;
    cplx_t smp;

    checks = 0; failures = 0; n_xfer = 0; obs_drop = 0; cycle = 0;
    rst_n = 1'b0; din_valid = 1'b0; din_sof = 1'b0; din_real = '0; din_imag = '0; dout_busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");

    // Ramp frame then full-scale frame, FFT always ready.
    for (int i = 0; i < 16; i++) begin
      tab[i].sof       = (i == 0) || (i == 8);
      tab[i].re        = (i < 8) ? 16'(i) : ((i % 2) ? 16'h8000 : 16'h7FFF);
      tab[i].im        = (i < 8) ? 16'h0000 : ((i % 2) ? 16'h7FFF : 16'h8000);
      tab[i].exp_valid = (i == 7) || (i == 15);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tab[i].sof, tab[i].re, tab[i].im, acc);
      chk($sformatf("tab%0d_valid", i), 128'(dout_valid), 128'(tab[i].exp_valid));
      if (i == 7) begin
`ifdef FFT_BITREV_EN
        chk("tab_slot1_real", 128'(dout_real[W +: W]), 128'(4));
`else
        chk("tab_slot1_real", 128'(dout_real[W +: W]), 128'(1));
`endif
      end
    end
    step(1'b0, 1'b0, '0, '0, acc);

    // Two frames back up behind a busy FFT, then drain in order.
    dout_busy = 1'b1;
    base_x = n_xfer;
    sent = 0;
    for (int c = 0; c < 40 && sent < 16; c++) begin
      step(1'b1, (sent % 8) == 0, 16'(sent), ~16'(sent), acc);
      if (acc) sent++;
    end
    chk("t2_busy_after_16", 128'(din_busy), 128'(1));
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 16'(sent), ~16'(sent), acc);
    dout_busy = 1'b0;
    for (int c = 0; c < 60 && sent < 24; c++) begin
      step(1'b1, (sent % 8) == 0, 16'(sent), ~16'(sent), acc);
      if (acc) sent++;
    end
    chk("t2_sent", 128'(sent), 128'(24));
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, '0, '0, acc);
    chk("t2_frames", 128'(n_xfer - base_x), 128'(3));

    // Continuous stream: five frames, one transfer every eight cycles, never busy.
    xfer_cyc.delete();
    base_x = n_xfer;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      smp.re = 16'($urandom);
      smp.im = 16'($urandom);
      step(1'b1, (i % 8) == 0, smp.re, smp.im, acc);
      busy_seen |= din_busy;
    end
    for (int c = 0; c < 2; c++) step(1'b0, 1'b0, '0, '0, acc);
    chk("t3_busy_seen", 128'(busy_seen), 128'(0));
    chk("t3_frames", 128'(n_xfer - base_x), 128'(5));
    for (int i = 1; i < 5 && i < xfer_cyc.size(); i++)
      chk($sformatf("t3_spacing%0d", i), 128'(xfer_cyc[i] - xfer_cyc[i-1]), 128'(8));

    // Partial frame abandoned by an early start-of-frame.
    base_d = obs_drop;
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 16'(50 + i), 16'h0, acc);
    step(1'b1, 1'b1, 16'd100, 16'h1, acc);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 16'(200 + i), 16'h0, acc);
    chk("t4_valid", 128'(dout_valid), 128'(1));
    chk("t4_slot0_real", 128'(dout_real[0 +: W]), 128'(100));
    step(1'b0, 1'b0, '0, '0, acc);
    chk("t4_drops", 128'(obs_drop - base_d), 128'(1));

    // Asynchronous reset with one bank full and the other half written.
    dout_busy = 1'b1;
    for (int i = 0; i < 13; i++) step(1'b1, (i % 8) == 0, 16'(300 + i), 16'(i), acc);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("t5_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    dout_busy = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 16'(400 + i), 16'(7 * i), acc);
    chk("t5_clean_valid", 128'(dout_valid), 128'(1));
    step(1'b0, 1'b0, '0, '0, acc);

    // Random traffic with random FFT back-pressure.
    for (int c = 0; c < 1500; c++) begin
      dout_busy = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           16'($urandom), 16'($urandom), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
